// File: rtl/row_deskewer_pkg.sv
// Shared definitions for the row de-skewer: default geometry and the FSM state type.
package row_deskewer_pkg;

  localparam int DEF_DIM_SIZE   = 4;
  localparam int DEF_ELEM_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = DEF_DIM_SIZE * DEF_ELEM_WIDTH;

  // Number of wavefronts that make up one frame.
  localparam int WAVES = 2 * DEF_DIM_SIZE - 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/row_deskewer_lane_extract.sv
// Picks one element out of a packed word; lane 0 is the most significant element.
module lane_extract #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEM_WIDTH = 8,
  parameter int LANE       = 0
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic [ELEM_WIDTH-1:0] elem
);

  assign elem = word[DATA_WIDTH-1-LANE*ELEM_WIDTH -: ELEM_WIDTH];

endmodule

// File: rtl/row_deskewer.sv
// Row de-skewer: collects a diagonal wavefront stream (2*DIM_SIZE-1 beats)
// and presents the reassembled rows as one frame.
// Optional feature: define ROW_DESKEWER_CHECK_EN to flag nonzero lanes that
// fall outside the wavefront window (sticky err_skew); otherwise err_skew is 0.
module row_deskewer
  import row_deskewer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM_SIZE   = DEF_DIM_SIZE,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_word,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_row0,
  output logic [DATA_WIDTH-1:0] out_row1,
  output logic [DATA_WIDTH-1:0] out_row2,
  output logic [DATA_WIDTH-1:0] out_row3,
  output logic                  err_skew
);

  localparam logic [2:0] LAST_BEAT = 3'(2 * DIM_SIZE - 2);

  state_t                 state;
  logic [2:0]             beat_cnt;
  logic                   accept;
  logic [ELEM_WIDTH-1:0]  lane_elem [DIM_SIZE];
  logic [DATA_WIDTH-1:0]  rows      [DIM_SIZE];

  assign accept = in_valid && in_ready && !clear;

  for (genvar j = 0; j < DIM_SIZE; j++) begin : g_lane
    lane_extract #(
      .DATA_WIDTH(DATA_WIDTH),
      .ELEM_WIDTH(ELEM_WIDTH),
      .LANE      (j)
    ) u_lane (
      .word(in_word),
      .elem(lane_elem[j])
    );
  end

  // Frame control: count accepted wavefronts, hold the finished frame until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      beat_cnt  <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= COLLECT;
      beat_cnt  <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              state     <= HOLD;
              beat_cnt  <= 3'd0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          beat_cnt  <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Row storage: lane j of wavefront k lands in row j, column k-j when inside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM_SIZE; r++) begin
        rows[r] <= '0;
      end
    end else if (accept) begin
      for (int j = 0; j < DIM_SIZE; j++) begin
        for (int c = 0; c < DIM_SIZE; c++) begin
          if (int'(beat_cnt) == j + c) begin
            rows[j][DATA_WIDTH-1-c*ELEM_WIDTH -: ELEM_WIDTH] <= lane_elem[j];
          end
        end
      end
    end
  end

  assign out_row0 = rows[0];
  assign out_row1 = rows[1];
  assign out_row2 = rows[2];
  assign out_row3 = rows[3];

`ifdef ROW_DESKEWER_CHECK_EN
  logic skew_hit;

  // Detect any nonzero lane that sits outside the window for the current beat.
  always_comb begin
    skew_hit = 1'b0;
    for (int j = 0; j < DIM_SIZE; j++) begin
      if (((int'(beat_cnt) < j) || (int'(beat_cnt) - j > DIM_SIZE - 1)) &&
          (lane_elem[j] != '0)) begin
        skew_hit = 1'b1;
      end
    end
  end

  // Sticky error flag, released only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_skew <= 1'b0;
    end else if (clear) begin
      err_skew <= 1'b0;
    end else if (accept && skew_hit) begin
      err_skew <= 1'b1;
    end
  end
`else
  assign err_skew = 1'b0;
`endif

endmodule

// File: tb/tb_row_deskewer.sv
// Directed testbench for row_deskewer with hand-computed frames.
module tb_row_deskewer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_row0, out_row1, out_row2, out_row3;
  logic        err_skew;

  int checks = 0;
  int failures = 0;

`ifdef ROW_DESKEWER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // Frame A: wavefronts and rows from the reference example.
  logic [31:0] waveA [7] = '{32'h01000000, 32'h02050000, 32'h03060900, 32'h04070A0D,
                             32'h00080B0E, 32'h00000C0F, 32'h00000010};
  logic [31:0] rowsA [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  // Frame B: rows 0x11121314 .. 0x41424344 skewed by hand.
  logic [31:0] waveB [7] = '{32'h11000000, 32'h12210000, 32'h13223100, 32'h14233241,
                             32'h00243342, 32'h00003443, 32'h00000044};
  logic [31:0] rowsB [4] = '{32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};

  row_deskewer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row0 (out_row0),
    .out_row1 (out_row1),
    .out_row2 (out_row2),
    .out_row3 (out_row3),
    .err_skew (err_skew)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle just past the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic c, input logic r);
    in_valid  = v;
    in_word   = w;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkRows(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    checkOutput({tag, "_row0"}, out_row0, e0);
    checkOutput({tag, "_row1"}, out_row1, e1);
    checkOutput({tag, "_row2"}, out_row2, e2);
    checkOutput({tag, "_row3"}, out_row3, e3);
  endtask

  // Send a full frame (0 = A, 1 = B), optionally idling gapLen cycles after beat gapAfter.
  // out_ready is held high through the early beats to show it is ignored in COLLECT.
  task automatic sendFrame(input int sel, input int gapAfter, input int gapLen, input string tag);
    for (int k = 0; k < 7; k++) begin
      checkOutput({tag, "_inReady"}, {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, (sel == 0) ? waveA[k] : waveB[k], 1'b0, (k < 6) ? 1'b1 : 1'b0);
      checkOutput({tag, "_outValid"}, {31'b0, out_valid}, (k == 6) ? 32'd1 : 32'd0);
      if (k == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          applyStimulus(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
          checkOutput({tag, "_gapValid"}, {31'b0, out_valid}, 32'd0);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_inReady", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, err_skew}, 32'd0);
    checkRows("rst", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back frame A
    sendFrame(0, -1, 0, "frameA");
    checkRows("frameA", rowsA[0], rowsA[1], rowsA[2], rowsA[3]);
    checkOutput("frameA_err", {31'b0, err_skew}, 32'd0);

    // Backpressure in HOLD: incoming beats must be refused and rows stay put
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      checkOutput("hold_inReady", {31'b0, in_ready}, 32'd0);
      checkOutput("hold_outValid", {31'b0, out_valid}, 32'd1);
    end
    checkRows("hold", rowsA[0], rowsA[1], rowsA[2], rowsA[3]);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    checkOutput("release_outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("release_inReady", {31'b0, in_ready}, 32'd1);
    checkRows("release", rowsA[0], rowsA[1], rowsA[2], rowsA[3]);

    // Frame B with a three-cycle gap after the third beat
    sendFrame(1, 2, 3, "gapB");
    checkRows("gapB", rowsB[0], rowsB[1], rowsB[2], rowsB[3]);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("gapB_release", {31'b0, out_valid}, 32'd0);

    // Abort after four beats of A (clear also discards a presented beat), then full B
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, waveA[k], 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
    checkOutput("clear_inReady", {31'b0, in_ready}, 32'd1);
    checkOutput("clear_outValid", {31'b0, out_valid}, 32'd0);
    clear = 1'b0;
    sendFrame(1, -1, 0, "afterClear");
    checkRows("afterClear", rowsB[0], rowsB[1], rowsB[2], rowsB[3]);

    // Clear while holding drops the frame but keeps storage
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("clearHold_outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("clearHold_inReady", {31'b0, in_ready}, 32'd1);
    checkRows("clearHold", rowsB[0], rowsB[1], rowsB[2], rowsB[3]);

    // Out-of-window lane on k=0
    applyStimulus(1'b1, 32'h01FF0000, 1'b0, 1'b0);
    checkOutput("skew_set", {31'b0, err_skew}, {31'b0, ERR_EXP});
    applyStimulus(1'b1, 32'h02050000, 1'b0, 1'b0);
    checkOutput("skew_sticky", {31'b0, err_skew}, {31'b0, ERR_EXP});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("skew_clear", {31'b0, err_skew}, 32'd0);
    clear = 1'b0;

    // Asynchronous reset after two beats
    applyStimulus(1'b1, waveB[0], 1'b0, 1'b0);
    applyStimulus(1'b1, waveB[1], 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midRst_inReady", {31'b0, in_ready}, 32'd1);
    checkRows("midRst", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendFrame(0, -1, 0, "postRst");
    checkRows("postRst", rowsA[0], rowsA[1], rowsA[2], rowsA[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_deskewer.md
ROW_DESKEWER -- requirements
Module: row_deskewer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every packed word; SHALL equal DIM_SIZE*ELEM_WIDTH.
REQ-002 Parameter DIM_SIZE, default 4, lanes per word, rows per frame and columns per row.
REQ-003 Parameter ELEM_WIDTH, default 8, bits per element; lane j occupies bits [DATA_WIDTH-1-j*ELEM_WIDTH -: ELEM_WIDTH], so lane 0 is the MSB byte.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  wavefront word present.
REQ-008 in_word  input  DATA_WIDTH  skewed wavefront word.
REQ-009 in_ready  output  1  block accepts in_word.
REQ-010 out_valid  output  1  reassembled frame present.
REQ-011 out_ready  input  1  consumer accepts frame.
REQ-012 out_row0..out_row3  output  DATA_WIDTH each  de-skewed rows, column 0 in the MSB lane.
REQ-013 err_skew  output  1  sticky out-of-window error flag (see REQ-030).

Function
REQ-014 A frame SHALL be 2*DIM_SIZE-1 (7) accepted wavefronts, numbered k=0..6 in acceptance order; a beat is accepted when in_valid&&in_ready.
REQ-015 Wavefront k, lane j SHALL be written to row j, column k-j, only when 0 <= k-j <= DIM_SIZE-1; other lanes are out-of-window and SHALL NOT be stored.
REQ-016 FSM states: COLLECT, HOLD.
REQ-017 COLLECT: in_ready=1, out_valid=0; a 3-bit beat counter increments on each accepted beat.
REQ-018 The accepted beat at counter value 6 SHALL transition to HOLD and reset the counter to 0.
REQ-019 HOLD: in_ready=0, out_valid=1, out_row0..3 stable; on out_ready=1 SHALL return to COLLECT next cycle.
REQ-020 Latency: out_valid SHALL rise on the first rising edge after the 7th beat is accepted.
REQ-021 in_valid=0 in COLLECT SHALL hold the counter and storage unchanged (gaps allowed).
REQ-022 out_row registers SHALL be updated only by accepted beats; values persist through HOLD and the next COLLECT until overwritten.
REQ-023 clear=1 SHALL force COLLECT and counter 0 next cycle, drop any held frame, and take priority over in_valid and out_ready in the same cycle; storage contents are not cleared.
REQ-024 A beat presented with clear=1 SHALL be discarded.
REQ-025 out_ready while in COLLECT SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state COLLECT, counter 0, out_row0..3 all 0, err_skew 0.
REQ-027 Outputs during reset: in_ready=1, out_valid=0.
REQ-028 Reset mid-frame SHALL discard partial frames; the first beat after release is k=0.

Configuration
REQ-029 Macro ROW_DESKEWER_CHECK_EN controls out-of-window checking.
REQ-030 Defined: any accepted beat with a nonzero out-of-window lane SHALL set err_skew, which stays set until clear or reset.
REQ-031 Undefined: out-of-window lanes are ignored and err_skew is tied to 0.

Structure
REQ-032 A shared package SHALL hold DIM_SIZE, ELEM_WIDTH, DATA_WIDTH defaults, WAVES=2*DIM_SIZE-1, and the FSM state enum.
REQ-033 Sub-module lane_extract SHALL return the element for a given lane index from a packed word; it is instantiated per lane.

Verification
REQ-034 Reset, then 7 beats 0x01000000, 0x02050000, 0x03060900, 0x04070A0D, 0x00080B0E, 0x00000C0F, 0x00000010 -> next cycle out_valid=1, out_row0..3 = 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10.
REQ-035 Same frame with in_valid low for 3 cycles between beats 3 and 4 -> identical rows; out_valid rises the edge after beat 7.
REQ-036 Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, rows unchanged, no beat counted; out_ready=1 -> COLLECT next cycle.
REQ-037 Assert clear after beat 4, then send a full new frame -> only the new frame's rows appear, with out_valid after its 7th beat.
REQ-038 With ROW_DESKEWER_CHECK_EN defined, beat k=0 = 0x01FF0000 -> err_skew=1 and sticky until clear; without the macro err_skew stays 0.
REQ-039 Pull rst_n low mid-frame (after beat 2) -> asynchronous out_valid=0, rows 0, in_ready=1; subsequent full frame is reassembled correctly.
